stream_equal_cmp: RTL and testbench
===================================

// Module: stream_equal_cmp
// PURPOSE
//   Parametrised, clocked successor to the 8-bit combinational equality checker.
//   Compares a burst of LEN operand pairs (num1, num2) under a selectable relation.
//   Per-pair results are registered; a burst summary is held after the burst ends.
//   The summary is a hit count, an all-hit flag and the index of the first miss.
//   Sits between a stimulus/operand source and a status/LED or self-check consumer.
// PARAMETERS
//   WIDTH    8   operand width in bits
//   CNT_W    8   width of len, index and hit counters; max burst = 2**CNT_W-1
//   SIGNED   0   1: LT/GT modes compare two's-complement; 0: unsigned
// PORTS
//   clk        in   1        single clock, all logic on rising edge
//   rst        in   1        synchronous, active-high reset
//   start      in   1        begin burst; sampled only in IDLE
//   len        in   CNT_W    pairs in burst, latched at start
//   mode       in   2        00 EQ, 01 NE, 10 LT (num1<num2), 11 GT; latched at start
//   valid      in   1        num1/num2 carry a pair this cycle
//   num1       in   WIDTH    operand A
//   num2       in   WIDTH    operand B
//   ready      out  1        1 only in RUN; pair accepted when valid&&ready
//   busy       out  1        1 in RUN
//   o          out  1        registered relation result of last accepted pair
//   o_valid    out  1        1-cycle pulse, o updated this cycle
//   done       out  1        1-cycle pulse on entering DONE
//   hit_cnt    out  CNT_W    pairs in burst satisfying relation
//   all_hit    out  1        hit_cnt == len (valid once done)
//   miss_idx   out  CNT_W    0-based index of first failing pair
//   miss_seen  out  1        at least one pair failed
// BEHAVIOUR
//   Reset: state=IDLE; every output 0; counters, latched len/mode cleared.
//   FSM: IDLE -> RUN on start && len!=0.
//   FSM: IDLE -> DONE on start && len==0; report all_hit=1, hit_cnt=0, miss_seen=0.
//   FSM: RUN -> DONE the cycle the len-th pair is accepted.
//   FSM: DONE -> IDLE after exactly 1 cycle.
//   start clears hit_cnt, miss_idx, miss_seen, all_hit and the index counter.
//   Summary outputs hold from DONE until the next accepted start or rst.
//   start while RUN or DONE is ignored. valid outside RUN is ignored.
//   Latency: pair accepted at edge N -> o/o_valid visible after edge N+1.
//   Latency: hit_cnt updates in that same cycle.
//   done rises after the edge following the last acceptance.
//   Final pair's o_valid and done assert in the same cycle.
//   Relation:
//     EQ  num1==num2; NE is its complement.
//     LT/GT per SIGNED; equal operands give 0 for both LT and GT.
//   First miss: on the first failing pair, miss_idx <= index and miss_seen <= 1.
//   Later misses do not change miss_idx.
//   Counters never wrap: len <= 2**CNT_W-1 bounds them.
//   all_hit is computed from the final hit_cnt and is written when entering DONE.
//   ready deasserts combinationally in the cycle after the last acceptance.
//   A valid pair presented then is not counted.
//   rst mid-burst: abort immediately; no done pulse; all outputs 0 next cycle.
//   o keeps its last value between o_valid pulses; it is cleared only by rst.
// TESTING
//   T1 Reset: assert rst mid-RUN.
//      -> next cycle state IDLE, all outputs 0, no done pulse.
//   T2 EQ, len=3: pairs (10h,10h),(FFh,FFh),(00h,00h).
//      -> o=1 x3, hit_cnt=3, all_hit=1, miss_seen=0, one done pulse.
//   T3 EQ, len=3: pairs (C6h,39h),(CAh,CAh),(62h,38h).
//      -> hit_cnt=1, all_hit=0, miss_idx=0, miss_seen=1.
//   T4 LT, SIGNED=0: (01h,80h)->o=1, (80h,01h)->o=0, (05h,05h)->o=0.
//      LT, SIGNED=1: (80h,01h)->o=1.
//   T5 Burst control, len=0: -> done one cycle after start, all_hit=1, hit_cnt=0.
//      Burst control, len=4: valid gaps between pairs -> done only after 4th accept.
//      Burst control, len=4: start pulsed mid-burst -> ignored.
//   T6 Back-to-back: start asserted the cycle after DONE -> new burst accepted.
//      Previous summary held until that start, then cleared.

Source files
------------

// File: rtl/stream_equal_cmp.sv
// Burst comparator: checks LEN operand pairs against a selectable relation
// (EQ/NE/LT/GT), registers per-pair results and holds a burst summary.
module stream_equal_cmp #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [1:0]       mode,
  input  logic             valid,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             ready,
  output logic             busy,
  output logic             o,
  output logic             o_valid,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             all_hit,
  output logic [CNT_W-1:0] miss_idx,
  output logic             miss_seen
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q, idx_q;
  logic [1:0]       mode_q;

  // Stage 1 holds the accepted pair; stage 2 evaluates it one edge later.
  logic             p_valid;
  logic [WIDTH-1:0] p_a, p_b;
  logic [CNT_W-1:0] p_idx;

  logic             accept, last;
  logic             lt, gt, rel;
  logic [CNT_W-1:0] hit_next;

  // Handshake: a pair transfers on a rising edge where valid && ready;
  // ready is high only in RUN and never depends on valid.
  assign ready  = (state == RUN);
  assign busy   = (state == RUN);
  assign accept = valid && ready;
  assign last   = accept && (idx_q == len_q - CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if (SIGNED != 0) begin
      lt = $signed(p_a) < $signed(p_b);
      gt = $signed(p_a) > $signed(p_b);
    end else begin
      lt = p_a < p_b;
      gt = p_a > p_b;
    end
    rel = 1'b0;
    case (mode_q)
      2'b00: rel = (p_a == p_b);
      2'b01: rel = (p_a != p_b);
      2'b10: rel = lt;
      2'b11: rel = gt;
      default: rel = 1'b0;
    endcase
  end

  assign hit_next = hit_cnt + {{(CNT_W-1){1'b0}}, p_valid & rel};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      mode_q    <= '0;
      idx_q     <= '0;
      p_valid   <= 1'b0;
      p_a       <= '0;
      p_b       <= '0;
      p_idx     <= '0;
      o         <= 1'b0;
      o_valid   <= 1'b0;
      done      <= 1'b0;
      hit_cnt   <= '0;
      all_hit   <= 1'b0;
      miss_idx  <= '0;
      miss_seen <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_valid <= 1'b0;
      done    <= 1'b0;
      p_valid <= accept;
      if (accept) begin
        p_a   <= num1;
        p_b   <= num2;
        p_idx <= idx_q;
        idx_q <= idx_q + CNT_W'(1);
      end
      if (p_valid) begin
        o       <= rel;
        o_valid <= 1'b1;
        hit_cnt <= hit_next;
        if (!rel && !miss_seen) begin
          miss_idx  <= p_idx;
          miss_seen <= 1'b1;
        end
      end
      // The last pair is still in stage 2 while in DONE, so use hit_next.
      if (state == DONE) begin
        done    <= 1'b1;
        all_hit <= (hit_next == len_q);
      end
      if (state == IDLE && start) begin
        len_q     <= len;
        mode_q    <= mode;
        idx_q     <= '0;
        hit_cnt   <= '0;
        miss_idx  <= '0;
        miss_seen <= 1'b0;
        all_hit   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_equal_cmp.sv
// Bench for stream_equal_cmp: unsigned and signed instances share stimulus and
// are checked against a burst-level reference model.
module tb_stream_equal_cmp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic [1:0] mode = '0;
  logic       valid = 1'b0;
  logic [7:0] num1 = '0;
  logic [7:0] num2 = '0;

  logic       ready_u, busy_u, o_u, o_valid_u, done_u, all_hit_u, miss_seen_u;
  logic [7:0] hit_cnt_u, miss_idx_u;
  logic       ready_s, busy_s, o_s, o_valid_s, done_s, all_hit_s, miss_seen_s;
  logic [7:0] hit_cnt_s, miss_idx_s;

  stream_equal_cmp #(.WIDTH(8), .CNT_W(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .valid(valid),
    .num1(num1), .num2(num2), .ready(ready_u), .busy(busy_u), .o(o_u),
    .o_valid(o_valid_u), .done(done_u), .hit_cnt(hit_cnt_u), .all_hit(all_hit_u),
    .miss_idx(miss_idx_u), .miss_seen(miss_seen_u)
  );

  stream_equal_cmp #(.WIDTH(8), .CNT_W(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode), .valid(valid),
    .num1(num1), .num2(num2), .ready(ready_s), .busy(busy_s), .o(o_s),
    .o_valid(o_valid_s), .done(done_s), .hit_cnt(hit_cnt_s), .all_hit(all_hit_s),
    .miss_idx(miss_idx_s), .miss_seen(miss_seen_s)
  );

  // clock/reset
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hit_u, idx_u;
    logic       all_u, seen_u;
    logic [7:0] hit_s, idx_s;
    logic       all_s, seen_s;
  } sum_t;

  logic [1:0] exp_q[$];   // {signed o, unsigned o} per accepted pair
  sum_t       sum_q[$];
  int         n_vec = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [7:0] last_hit_u = '0, last_hit_s = '0;
  logic [7:0] pa[64], pb[64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ref_rel(input logic [1:0] m, input logic [7:0] a,
                                   input logic [7:0] b, input bit sgn);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (sgn && a >= 8'd128) ia = ia - 256;
    if (sgn && b >= 8'd128) ib = ib - 256;
    case (m)
      2'd0:    return a == b;
      2'd1:    return a != b;
      2'd2:    return ia < ib;
      default: return ia > ib;
    endcase
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (o_valid_u === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_o_valid", 1, 0);
        else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("o_u", o_u, e[0]);
          chk("o_s", o_s, e[1]);
          chk("o_valid_s", o_valid_s, 1);
        end
      end
      if (done_u === 1'b1) begin
        if (sum_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          sum_t s;
          s = sum_q.pop_front();
          chk("hit_cnt_u", hit_cnt_u, s.hit_u);
          chk("all_hit_u", all_hit_u, s.all_u);
          chk("miss_idx_u", miss_idx_u, s.idx_u);
          chk("miss_seen_u", miss_seen_u, s.seen_u);
          chk("done_s", done_s, 1);
          chk("hit_cnt_s", hit_cnt_s, s.hit_s);
          chk("all_hit_s", all_hit_s, s.all_s);
          chk("miss_idx_s", miss_idx_s, s.idx_s);
          chk("miss_seen_s", miss_seen_s, s.seen_s);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in the cycle
  // the done pulse is visible (the DUT is back in IDLE then).
  task automatic run_burst(input int n, input logic [1:0] m, input int max_gap,
                           input bit mid_start);
    sum_t s;
    s = '{default: '0};
    for (int i = 0; i < n; i++) begin
      logic ru, rs;
      ru = ref_rel(m, pa[i], pb[i], 1'b0);
      rs = ref_rel(m, pa[i], pb[i], 1'b1);
      exp_q.push_back({rs, ru});
      if (ru) s.hit_u++;
      else if (!s.seen_u) begin s.seen_u = 1'b1; s.idx_u = 8'(i); end
      if (rs) s.hit_s++;
      else if (!s.seen_s) begin s.seen_s = 1'b1; s.idx_s = 8'(i); end
    end
    s.all_u = (int'(s.hit_u) == n);
    s.all_s = (int'(s.hit_s) == n);
    sum_q.push_back(s);

    chk("held_hit_u", hit_cnt_u, last_hit_u);
    chk("held_hit_s", hit_cnt_s, last_hit_s);
    start = 1'b1; len = 8'(n); mode = m;
    tick();
    start = 1'b0;
    chk("clr_hit", hit_cnt_u, 0);
    chk("clr_seen", miss_seen_u, 0);
    chk("clr_all", all_hit_u, 0);
    chk("clr_idx", miss_idx_u, 0);
    if (n == 0) begin
      chk("len0_busy", busy_u, 0);
      chk("len0_done_early", done_u, 0);
      tick();
      chk("len0_done", done_u, 1);
    end else begin
      chk("run_ready", ready_u, 1);
      for (int i = 0; i < n; i++) begin
        int g;
        g = $urandom_range(0, max_gap);
        if (mid_start && i == 2 && g == 0) g = 1;
        for (int k = 0; k < g; k++) begin
          start = (mid_start && i == 2 && k == 0);
          len = 8'd1;
          mode = ~m;
          num1 = 8'($urandom);
          num2 = 8'($urandom);
          tick();
        end
        start = 1'b0;
        valid = 1'b1; num1 = pa[i]; num2 = pb[i];
        tick();
        valid = 1'b0;
      end
      chk("ready_drop", ready_u, 0);
      chk("busy_drop", busy_u, 0);
      chk("done_early", done_u, 0);
      valid = 1'b1; num1 = 8'($urandom); num2 = 8'($urandom);
      tick();
      valid = 1'b0;
      chk("done_pulse", done_u, 1);
      chk("last_o_valid", o_valid_u, 1);
    end
    last_hit_u = s.hit_u;
    last_hit_s = s.hit_s;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy_u, 0);
    chk({tag, "_ready"}, ready_u, 0);
    chk({tag, "_o"}, {o_u, o_s}, 0);
    chk({tag, "_ov"}, {o_valid_u, o_valid_s}, 0);
    chk({tag, "_done"}, {done_u, done_s}, 0);
    chk({tag, "_hit"}, {hit_cnt_u, hit_cnt_s}, 0);
    chk({tag, "_all"}, {all_hit_u, all_hit_s}, 0);
    chk({tag, "_idx"}, {miss_idx_u, miss_idx_s}, 0);
    chk({tag, "_seen"}, {miss_seen_u, miss_seen_s}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_zero("reset");
    mon_en = 1'b1;

    // all-equal EQ burst
    pa[0] = 8'h10; pb[0] = 8'h10; pa[1] = 8'hFF; pb[1] = 8'hFF; pa[2] = 8'h00; pb[2] = 8'h00;
    run_burst(3, 2'b00, 0, 1'b0);
    chk("t2_all_hit", all_hit_u, 1);
    tick();

    // EQ burst with misses at 0 and 2
    pa[0] = 8'hC6; pb[0] = 8'h39; pa[1] = 8'hCA; pb[1] = 8'hCA; pa[2] = 8'h62; pb[2] = 8'h38;
    run_burst(3, 2'b00, 1, 1'b0);
    tick(); tick();

    // LT then GT: unsigned vs signed ordering
    pa[0] = 8'h01; pb[0] = 8'h80; pa[1] = 8'h80; pb[1] = 8'h01; pa[2] = 8'h05; pb[2] = 8'h05;
    run_burst(3, 2'b10, 0, 1'b0);
    run_burst(3, 2'b11, 0, 1'b0);
    tick();

    // valid while idle must be ignored
    valid = 1'b1; num1 = 8'h11; num2 = 8'h11;
    tick(); tick();
    valid = 1'b0;

    // zero-length burst, then len=4 with gaps and an ignored mid-burst start
    run_burst(0, 2'b01, 0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin pa[i] = 8'(i * 3); pb[i] = 8'(i * 5); end
    run_burst(4, 2'b01, 3, 1'b1);
    tick();

    // reset in the middle of a burst
    mon_en = 1'b0;
    start = 1'b1; len = 8'd5; mode = 2'b00;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1; num1 = 8'h5A; num2 = 8'h5A;
      tick();
    end
    valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("mid_rst");
    tick();
    chk_zero("post_rst");
    last_hit_u = '0; last_hit_s = '0;
    mon_en = 1'b1;

    // randomized bursts, some back-to-back
    for (int b = 0; b < 20; b++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        pa[i] = 8'($urandom);
        pb[i] = ($urandom_range(0, 1) == 1) ? pa[i] : 8'($urandom);
      end
      run_burst(n, 2'($urandom_range(0, 3)), 2, (b % 4) == 0);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end

    tick(); tick();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("sum_q_drained", sum_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
